// File: rtl/rotate_shift_pipe_pkg.sv
// Shared ALU definitions: shift/rotate mode encodings and the data-width legality check.
package rotate_shift_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_ROR = 2'b00,
    MODE_ROL = 2'b01,
    MODE_SRL = 2'b10,
    MODE_SRA = 2'b11
  } mode_e;

  localparam int unsigned MIN_WIDTH = 8;
  localparam int unsigned MAX_WIDTH = 64;

  // Legal data widths are powers of two within [MIN_WIDTH, MAX_WIDTH].
  function automatic bit width_ok(input int unsigned w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/rotate_shift_pipe_if.sv
// Request/result handshake bundle for the pipelined rotate/shift unit.
interface rotate_shift_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shift;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_shift, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shift, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/rotate_shift_stage.sv
// One log-shifter stage: conditional shift/rotate by DIST, then the stage register.
module rotate_shift_stage
  import rotate_shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  input  logic [SHW-1:0]   d_shift,
  input  mode_e            d_mode,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data,
  output logic [SHW-1:0]   q_shift,
  output mode_e            q_mode
);

  localparam int unsigned BIT = $clog2(DIST);

  logic [WIDTH-1:0] shifted_c;

  // SRA fills with the current MSB; earlier SRA stages never alter it, so it is the original sign.
  always_comb begin
    shifted_c = d_data;
    if (d_shift[BIT]) begin
      case (d_mode)
        MODE_ROR: shifted_c = {d_data[DIST-1:0], d_data[WIDTH-1:DIST]};
        MODE_ROL: shifted_c = {d_data[WIDTH-DIST-1:0], d_data[WIDTH-1:WIDTH-DIST]};
        MODE_SRL: shifted_c = {{DIST{1'b0}}, d_data[WIDTH-1:DIST]};
        MODE_SRA: shifted_c = {{DIST{d_data[WIDTH-1]}}, d_data[WIDTH-1:DIST]};
        default:  shifted_c = d_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
    end else if (clr) begin
      q_valid <= 1'b0;
    end else if (en) begin
      q_valid <= d_valid;
    end
  end

  // Payload keeps its value across flush/reset and only loads real requests.
  always_ff @(posedge clk) begin
    if (en && !clr && d_valid) begin
      q_data  <= shifted_c;
      q_shift <= d_shift;
      q_mode  <= d_mode;
    end
  end

endmodule

// File: rtl/rotate_shift_pipe.sv
// Pipelined rotate/shift unit: SHW registered log-shifter stages with a global stall.
module rotate_shift_pipe
  import rotate_shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  rotate_shift_pipe_if.slave bus
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("rotate_shift_pipe: WIDTH must be a power of two between 8 and 64");
  end

  logic advance_c;
  logic accept_c;

  logic             stg_valid [SHW+1];
  logic [WIDTH-1:0] stg_data  [SHW+1];
  logic [SHW-1:0]   stg_shift [SHW+1];
  mode_e            stg_mode  [SHW+1];

  // The whole pipe moves together; a held result freezes every stage, bubbles included.
  assign advance_c    = bus.out_ready || !bus.out_valid;
  assign bus.in_ready = !rst && !flush && advance_c;
  assign accept_c     = bus.in_valid && bus.in_ready;

  assign stg_valid[0] = accept_c;
  assign stg_data[0]  = bus.in_data;
  assign stg_shift[0] = bus.in_shift;
  assign stg_mode[0]  = mode_e'(bus.in_mode);

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    rotate_shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (32'(1) << k),
      .SHW   (SHW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (advance_c),
      .clr     (flush),
      .d_valid (stg_valid[k]),
      .d_data  (stg_data[k]),
      .d_shift (stg_shift[k]),
      .d_mode  (stg_mode[k]),
      .q_valid (stg_valid[k+1]),
      .q_data  (stg_data[k+1]),
      .q_shift (stg_shift[k+1]),
      .q_mode  (stg_mode[k+1])
    );
  end

  assign bus.out_valid = stg_valid[SHW];
  assign bus.out_data  = stg_data[SHW];
  assign bus.out_zero  = (stg_data[SHW] == '0);

endmodule
